// File: rtl/pi2c_pkg.sv
// pi2c_pkg: shared types and constants for the pi2c_target I2C register responder.
package pi2c_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
   } state_t;
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
   localparam int   BYTE_W   = 8;
endpackage

// File: rtl/pi2c_sync_edge.sv
// pi2c_sync_edge: 2-flop synchronizer plus rise/fall detect for one I2C line.
// PI2C_TARGET_FILTER_EN adds a 3-sample hold filter that rejects spikes up to 2 clk wide.
module pi2c_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic [1:0] r_sync;
   logic       r_lvl;
   logic       w_lvl;
   always_ff @(posedge clk) r_sync <= reset ? 2'b11 : {r_sync[0], i_line};
`ifdef PI2C_TARGET_FILTER_EN
   logic [1:0] r_flt;
   always_ff @(posedge clk) r_flt <= reset ? 2'b11 : {r_flt[0], r_sync[1]};
   // a new level is taken only when three consecutive samples agree, else the last level holds
   assign w_lvl = (r_sync[1] == r_flt[0] && r_flt[0] == r_flt[1]) ? r_sync[1] : r_lvl;
`else
   assign w_lvl = r_sync[1];
`endif
   always_ff @(posedge clk) r_lvl <= reset ? 1'b1 : w_lvl;
   assign o_level = w_lvl;
   assign o_rise  = w_lvl & ~r_lvl;
   assign o_fall  = ~w_lvl & r_lvl;
endmodule

// File: rtl/pi2c_target.sv
// pi2c_target: I2C target serving a byte register file with pointer auto-increment.
// Optional SCL/SDA glitch filter enabled by PI2C_TARGET_FILTER_EN.
module pi2c_target
   import pi2c_pkg::*;
#(
   parameter logic [6:0] ADDR = 7'h50,
   parameter int         REGS = 16,
   parameter int         PW   = $clog2(REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i2c_scl_i,
   input  logic              i2c_sda_i,
   output logic              i2c_scl_o,
   output logic              i2c_scl_t,
   output logic              i2c_sda_o,
   output logic              i2c_sda_t,
   output logic [8*REGS-1:0] regs_out,
   output logic              wr_pulse,
   output logic [PW-1:0]     wr_ptr,
   output logic              busy
);
   localparam logic [3:0] NBITS = 4'(BYTE_W);
   state_t            r_state;
   logic [7:0]        r_shift;
   logic [3:0]        r_cnt;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [8*REGS-1:0] r_regs;
   logic              r_sda_t;
   logic              r_busy;
   logic              r_wr_pulse;
   logic              w_scl, w_scl_rise, w_scl_fall;
   logic              w_sda, w_sda_rise, w_sda_fall;
   logic              w_start, w_stop, w_done;
   logic [7:0]        w_rd;
   pi2c_sync_edge u_scl (.clk(clk), .reset(reset), .i_line(i2c_scl_i),
                         .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
   pi2c_sync_edge u_sda (.clk(clk), .reset(reset), .i_line(i2c_sda_i),
                         .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));
   assign w_start   = w_sda_fall & w_scl;
   assign w_stop    = w_sda_rise & w_scl;
   assign w_done    = r_cnt == NBITS;
   assign w_rd      = r_regs[{r_ptr, 3'b000} +: 8];
   assign i2c_scl_o = 1'b0;
   assign i2c_scl_t = 1'b1;
   assign i2c_sda_o = 1'b0;
   assign i2c_sda_t = r_sda_t;
   assign regs_out  = r_regs;
   assign wr_pulse  = r_wr_pulse;
   assign wr_ptr    = r_wr_ptr;
   assign busy      = r_busy;
   // bits are sampled on SCL rise; SDA only changes on SCL fall, which also closes each byte/ACK slot
   always_ff @(posedge clk) begin
      r_wr_pulse <= 1'b0;
      if (reset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_ptr    <= '0;
         r_wr_ptr <= '0;
         r_regs   <= '0;
         r_sda_t  <= 1'b1;
         r_busy   <= 1'b0;
      end else if (w_stop) begin
         r_state <= S_IDLE;
         r_sda_t <= 1'b1;
         r_busy  <= 1'b0;
      end else if (w_start) begin
         r_state <= S_ADDR;
         r_sda_t <= 1'b1;
         r_cnt   <= '0;
      end else if (w_scl_rise) begin
         if (r_state inside {S_ADDR, S_PTR, S_WDATA}) begin
            r_shift <= {r_shift[6:0], w_sda};
            r_cnt   <= r_cnt + 4'd1;
         end
         if (r_state == S_RDATA) r_cnt <= r_cnt + 4'd1;
         if (r_state == S_RDATA_ACK && w_sda == I2C_NACK) r_state <= S_IDLE;
      end else if (w_scl_fall) begin
         case (r_state)
            S_ADDR: if (w_done) begin
               r_state <= (r_shift[7:1] == ADDR) ? S_ADDR_ACK : S_IDLE;
               r_sda_t <= (r_shift[7:1] == ADDR) ? I2C_ACK : 1'b1;
               r_busy  <= r_busy | (r_shift[7:1] == ADDR);
            end
            S_ADDR_ACK: begin
               r_cnt   <= '0;
               r_state <= r_shift[0] ? S_RDATA : S_PTR;
               r_sda_t <= r_shift[0] ? w_rd[7] : 1'b1;
               if (r_shift[0]) r_shift <= {w_rd[6:0], 1'b0};
            end
            S_PTR: if (w_done) begin
               r_ptr   <= r_shift[PW-1:0];
               r_state <= S_PTR_ACK;
               r_sda_t <= I2C_ACK;
            end
            S_PTR_ACK, S_WDATA_ACK: begin
               r_state <= S_WDATA;
               r_sda_t <= 1'b1;
               r_cnt   <= '0;
            end
            S_WDATA: if (w_done) begin
               r_regs[{r_ptr, 3'b000} +: 8] <= r_shift;
               r_wr_pulse <= 1'b1;
               r_wr_ptr   <= r_ptr;
               r_ptr      <= r_ptr + 1'b1;
               r_state    <= S_WDATA_ACK;
               r_sda_t    <= I2C_ACK;
            end
            S_RDATA: begin
               r_state <= w_done ? S_RDATA_ACK : S_RDATA;
               r_sda_t <= w_done ? 1'b1 : r_shift[7];
               r_ptr   <= w_done ? r_ptr + 1'b1 : r_ptr;
               r_shift <= {r_shift[6:0], 1'b0};
            end
            S_RDATA_ACK: begin
               r_state <= S_RDATA;
               r_sda_t <= w_rd[7];
               r_shift <= {w_rd[6:0], 1'b0};
               r_cnt   <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule
